// File: rtl/uart_rx_sampler_if.sv
// Signal bundle between a UART line driver and the oversampling receiver.
// master drives the line and enable; slave is the receiver.
interface uart_rx_sampler_if;
    logic       rx;
    logic       rx_en;
    logic [7:0] data_o;
    logic       word_done;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       busy_o;

    modport master (
        output rx, rx_en,
        input  data_o, word_done, parity_err_o, frame_err_o, busy_o
    );

    modport slave (
        input  rx, rx_en,
        output data_o, word_done, parity_err_o, frame_err_o, busy_o
    );
endinterface

// File: rtl/uart_rx_sampler.sv
// Fixed-baud oversampling UART receiver: 8 data bits LSB first, optional even
// parity, framing/parity error flags and a one-cycle word_done strobe.
module uart_rx_sampler #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 3125000,
    parameter int unsigned PARITY_EN = 0
) (
    input logic              clk,
    input logic              rst_n,
    uart_rx_sampler_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned HALF         = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               par_bad_q, par_bad_d;
    logic [7:0]         data_q, data_d;
    logic               word_done_q, word_done_d;
    logic               parity_err_q, parity_err_d;
    logic               frame_err_q, frame_err_d;
    logic               rx_meta_q, rx_s_q, rx_s_d_q;
    logic               expire;

    assign expire = (cnt_q == CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        data_d       = data_q;
        word_done_d  = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (state_q != IDLE && !expire) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.rx_en && !rx_s_q && rx_s_d_q) begin
                    state_d = START;
                    cnt_d   = CNT_W'(HALF);
                end
            end
            START: begin
                if (expire) begin
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        cnt_d     = CNT_W'(CLKS_PER_BIT);
                        idx_d     = 3'd0;
                        par_bad_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (expire) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    cnt_d   = CNT_W'(CLKS_PER_BIT);
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (expire) begin
                    par_bad_d = (^shift_q) ^ rx_s_q;
                    cnt_d     = CNT_W'(CLKS_PER_BIT);
                    state_d   = STOP;
                end
            end
            STOP: begin
                if (expire) begin
                    data_d       = shift_q;
                    parity_err_d = par_bad_q;
                    frame_err_d  = ~rx_s_q;
                    word_done_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over a coincident stop-bit expiry: nothing is delivered.
        if (state_q != IDLE && !bus.rx_en) begin
            state_d      = IDLE;
            word_done_d  = 1'b0;
            data_d       = data_q;
            parity_err_d = parity_err_q;
            frame_err_d  = frame_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            rx_s_d_q     <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            data_q       <= '0;
            word_done_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= bus.rx;
            rx_s_q       <= rx_meta_q;
            rx_s_d_q     <= rx_s_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            data_q       <= data_d;
            word_done_q  <= word_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.data_o       = data_q;
    assign bus.word_done    = word_done_q;
    assign bus.parity_err_o = parity_err_q;
    assign bus.frame_err_o  = frame_err_q;
    assign bus.busy_o       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: one receiver without parity, one with even parity.
module tb_uart_rx_sampler;
    localparam int unsigned CPB  = 16;
    localparam int unsigned HALF = CPB / 2;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned cyc;
    } word_t;

    typedef struct {
        int unsigned w;
        logic [7:0]  d;
        logic        pbit;
        logic        stop;
        logic [7:0]  exp_d;
        logic        exp_pe;
        logic        exp_fe;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx0 = 1'b1, rx1 = 1'b1, en0 = 1'b1, en1 = 1'b1;
    int unsigned cyc = 0;
    int unsigned n_chk = 0, n_pass = 0;
    int unsigned fall_cyc;
    logic [7:0] last_data0;
    word_t q0[$], q1[$];
    logic prev0 = 1'b0, prev1 = 1'b0;

    uart_rx_sampler_if bus0();
    uart_rx_sampler_if bus1();
    assign bus0.rx = rx0;
    assign bus0.rx_en = en0;
    assign bus1.rx = rx1;
    assign bus1.rx_en = en1;

    uart_rx_sampler dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    uart_rx_sampler #(.PARITY_EN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (prev0) chk("wd0_width", 32'(bus0.word_done), 32'd0);
        if (prev1) chk("wd1_width", 32'(bus1.word_done), 32'd0);
        prev0 <= bus0.word_done;
        prev1 <= bus1.word_done;
        if (bus0.word_done) q0.push_back('{bus0.data_o, bus0.parity_err_o, bus0.frame_err_o, cyc});
        if (bus1.word_done) q1.push_back('{bus1.data_o, bus1.parity_err_o, bus1.frame_err_o, cyc});
    end

    // Reference: a frame's outcome follows from its bits alone; strobe lands
    // 3 sync cycles + half a bit + (9 or 10) whole bits after the start edge.
    function automatic word_t model(input int unsigned w, input logic [7:0] d,
                                    input logic p, input logic stop);
        word_t r;
        r.d   = d;
        r.pe  = (w == 1) ? ((^d) ^ p) : 1'b0;
        r.fe  = ~stop;
        r.cyc = 3 + HALF + (9 + w) * CPB;
        return r;
    endfunction

    task automatic set_rx(input int unsigned w, input logic v);
        if (w == 0) rx0 = v; else rx1 = v;
    endtask

    task automatic hold(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int unsigned w, input logic v);
        set_rx(w, v);
        hold(CPB);
    endtask

    task automatic send_frame(input int unsigned w, input logic [7:0] d,
                              input logic pbit, input logic stop);
        fall_cyc = cyc;
        send_bit(w, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(w, d[i]);
        if (w == 1) send_bit(w, pbit);
        send_bit(w, stop);
    endtask

    task automatic expect_word(input string tag, input int unsigned w, input word_t e);
        word_t got;
        int unsigned sz;
        sz = (w == 0) ? q0.size() : q1.size();
        chk({tag, "_count"}, 32'(sz), 32'd1);
        if (sz > 0) begin
            got = (w == 0) ? q0.pop_front() : q1.pop_front();
            chk({tag, "_data"}, 32'(got.d), 32'(e.d));
            chk({tag, "_perr"}, 32'(got.pe), 32'(e.pe));
            chk({tag, "_ferr"}, 32'(got.fe), 32'(e.fe));
            chk({tag, "_lat"}, got.cyc - fall_cyc, e.cyc);
        end
        if (w == 0) begin
            q0.delete();
            last_data0 = e.d;
        end else begin
            q1.delete();
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[7];
        logic [7:0] d;
        word_t e1, e2;
        int unsigned f1;

        tbl[0] = '{0, 8'h41, 1'b0, 1'b0, 8'h41, 1'b0, 1'b1};
        tbl[1] = '{0, 8'h5A, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        tbl[2] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[3] = '{1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0};
        tbl[4] = '{1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[5] = '{1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[6] = '{1, 8'h80, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};

        hold(3);
        chk("rst_data", 32'(bus0.data_o), 32'd0);
        chk("rst_wd", 32'(bus0.word_done), 32'd0);
        chk("rst_perr", 32'(bus1.parity_err_o), 32'd0);
        chk("rst_ferr", 32'(bus0.frame_err_o), 32'd0);
        chk("rst_busy", 32'(bus0.busy_o), 32'd0);
        rst_n = 1'b1;
        hold(5);

        // Back-to-back frames with no idle gap
        f1 = cyc;
        send_frame(0, 8'h55, 1'b0, 1'b1);
        send_frame(0, 8'hA3, 1'b0, 1'b1);
        hold(4);
        chk("b2b_count", 32'(q0.size()), 32'd2);
        if (q0.size() == 2) begin
            e1 = q0.pop_front();
            e2 = q0.pop_front();
            chk("b2b_d1", 32'(e1.d), 32'h55);
            chk("b2b_d2", 32'(e2.d), 32'hA3);
            chk("b2b_err", 32'({e1.pe, e1.fe, e2.pe, e2.fe}), 32'd0);
            chk("b2b_lat", e1.cyc - f1, 3 + HALF + 9 * CPB);
            chk("b2b_gap", e2.cyc - e1.cyc, 10 * CPB);
        end
        q0.delete();
        last_data0 = 8'hA3;

        for (int i = 0; i < 7; i++) begin
            word_t ev;
            send_frame(tbl[i].w, tbl[i].d, tbl[i].pbit, tbl[i].stop);
            set_rx(tbl[i].w, 1'b1);
            hold(4);
            ev = model(tbl[i].w, tbl[i].exp_d, 1'b0, 1'b1);
            ev.pe = tbl[i].exp_pe;
            ev.fe = tbl[i].exp_fe;
            expect_word($sformatf("vec%0d", i), tbl[i].w, ev);
        end

        // Framing error followed by a held break: one word only
        send_frame(0, 8'h41, 1'b0, 1'b0);
        hold(3 * CPB);
        expect_word("break", 0, model(0, 8'h41, 1'b0, 1'b0));
        chk("break_busy", 32'(bus0.busy_o), 32'd0);
        set_rx(0, 1'b1);
        hold(4);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        hold(4);
        expect_word("clear", 0, model(0, 8'h12, 1'b0, 1'b1));

        // Short low glitch on an idle line
        set_rx(0, 1'b0);
        hold(3);
        set_rx(0, 1'b1);
        hold(2);
        chk("glitch_busy_hi", 32'(bus0.busy_o), 32'd1);
        hold(20);
        chk("glitch_busy_lo", 32'(bus0.busy_o), 32'd0);
        chk("glitch_count", 32'(q0.size()), 32'd0);
        chk("glitch_data", 32'(bus0.data_o), 32'(last_data0));

        // Enable dropped during data bit 3
        d = 8'h3C;
        send_bit(0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(0, d[i]);
        set_rx(0, d[3]);
        hold(4);
        en0 = 1'b0;
        hold(2);
        chk("abort_busy", 32'(bus0.busy_o), 32'd0);
        hold(CPB - 6);
        for (int i = 4; i < 8; i++) send_bit(0, d[i]);
        send_bit(0, 1'b1);
        hold(4);
        chk("abort_count", 32'(q0.size()), 32'd0);
        chk("abort_data", 32'(bus0.data_o), 32'(last_data0));

        // Whole frame with enable low
        set_rx(0, 1'b0);
        hold(10);
        chk("dis_busy", 32'(bus0.busy_o), 32'd0);
        hold(CPB - 10);
        for (int i = 0; i < 8; i++) send_bit(0, d[i]);
        send_bit(0, 1'b1);
        hold(4);
        chk("dis_count", 32'(q0.size()), 32'd0);
        en0 = 1'b1;
        hold(4);

        // Reset asserted during data bit 5 of 0xFF
        d = 8'hFF;
        send_bit(0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(0, d[i]);
        set_rx(0, 1'b1);
        hold(8);
        rst_n = 1'b0;
        #1;
        chk("mrst_data", 32'(bus0.data_o), 32'd0);
        chk("mrst_flags", 32'({bus0.word_done, bus0.parity_err_o, bus0.frame_err_o}), 32'd0);
        chk("mrst_busy", 32'(bus0.busy_o), 32'd0);
        hold(2);
        rst_n = 1'b1;
        hold(3 * CPB);
        chk("mrst_count", 32'(q0.size()), 32'd0);
        send_frame(0, 8'h12, 1'b0, 1'b1);
        hold(4);
        expect_word("post_rst", 0, model(0, 8'h12, 1'b0, 1'b1));

        // Randomised frames against the reference
        for (int i = 0; i < 24; i++) begin
            int unsigned w;
            logic [7:0] rd;
            logic p, s;
            w  = $urandom_range(0, 1);
            rd = 8'($urandom);
            p  = 1'($urandom_range(0, 1));
            s  = ($urandom_range(0, 3) != 0);
            send_frame(w, rd, p, s);
            set_rx(w, 1'b1);
            hold($urandom_range(1, 12));
            expect_word($sformatf("rnd%0d", i), w, model(w, rd, p, s));
        end

        hold(4);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
